// File: rtl/ram_bist_pkg.sv
// rtl/ram_bist_pkg.sv - shared types and pattern generation for the RAM BIST engine
//
// Purpose: pattern mode and FSM state types, the checkerboard constant and the
// address-to-data pattern function used by both the write side and the checker.
// Ports: none (package).
package ram_bist_pkg;

  // Widest supported data path / address; callers truncate to their own widths.
  localparam int MAX_DATA_WIDTH = 1152;
  localparam int MAX_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    MODE_CNT_DN   = 2'd0,
    MODE_ADDR     = 2'd1,
    MODE_CHK      = 2'd2,
    MODE_ADDR_INV = 2'd3
  } bist_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_GAP   = 3'd2,
    ST_READ  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } bist_state_e;

  // 0x55.. across the full maximum width.
  function automatic logic [MAX_DATA_WIDTH-1:0] chk_const();
    return {(MAX_DATA_WIDTH/2){2'b01}};
  endfunction

  // Full-width pattern; truncation to the real data width is left to the caller.
  // All-ones minus a, modulo 2**w, equals ~a truncated to w bits, so the
  // descending counter and the inverted address share the same expression.
  function automatic logic [MAX_DATA_WIDTH-1:0] bist_pattern(
    input bist_mode_e                mode,
    input logic [MAX_ADDR_WIDTH-1:0] addr
  );
    logic [MAX_DATA_WIDTH-1:0] a_ext;
    logic [MAX_DATA_WIDTH-1:0] pat;
    a_ext = {{(MAX_DATA_WIDTH-MAX_ADDR_WIDTH){1'b0}}, addr};
    pat   = '0;
    case (mode)
      MODE_CNT_DN:   pat = ~a_ext;
      MODE_ADDR:     pat = a_ext;
      MODE_CHK:      pat = addr[0] ? ~chk_const() : chk_const();
      MODE_ADDR_INV: pat = ~a_ext;
      default:       pat = '0;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/ram_2port_bist_if.sv
// rtl/ram_2port_bist_if.sv - simple dual-port RAM access bus driven by the BIST
//
// Purpose: bundles the RAM write port and read port.
// Signals: ram_wr_en/ram_wr_addr/ram_wr_data (write port), ram_rd_addr (read
// address), ram_rd_data (read data returned by the RAM).
// Modports: master = BIST side, slave = RAM side.
interface ram_2port_bist_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
);
  logic                  ram_wr_en;
  logic [ADDR_WIDTH-1:0] ram_wr_addr;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  modport master (
    output ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr,
    input  ram_rd_data
  );

  modport slave (
    input  ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr,
    output ram_rd_data
  );
endinterface

// File: rtl/ram_bist_chk.sv
// rtl/ram_bist_chk.sv - read-data checker: expected-data pipeline, compare, error count
//
// Purpose: regenerates the pattern for each read address, delays it by
// RD_LATENCY cycles to line up with ram_rd_data, compares, and keeps a
// saturating mismatch counter. Optional error log under RAM_2PORT_BIST_ERR_LOG_EN.
// Ports: clk, rst_n (sync active-low), clr (accepted start), mode, rd_vld/rd_addr
// (address driven this cycle), rd_data (RAM output), err_cnt; with the macro
// also first_err_addr/first_err_data.
module ram_bist_chk
  import ram_bist_pkg::*;
#(
  parameter int ADDR_WIDTH    = 5,
  parameter int DATA_WIDTH    = 8,
  parameter int RD_LATENCY    = 1,
  parameter int ERR_CNT_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  bist_mode_e               mode,
  input  logic                     rd_vld,
  input  logic [ADDR_WIDTH-1:0]    rd_addr,
  input  logic [DATA_WIDTH-1:0]    rd_data,
`ifdef RAM_2PORT_BIST_ERR_LOG_EN
  output logic [ADDR_WIDTH-1:0]    first_err_addr,
  output logic [DATA_WIDTH-1:0]    first_err_data,
`endif
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

  logic [RD_LATENCY-1:0] vld_pipe;
  logic [DATA_WIDTH-1:0] exp_pipe [RD_LATENCY];
  logic [DATA_WIDTH-1:0] exp_now;
  logic                  mismatch;

  assign exp_now = DATA_WIDTH'(bist_pattern(mode, MAX_ADDR_WIDTH'(rd_addr)));

  // Stage 0 captures the address issued this cycle; the last stage is
  // aligned with the RAM output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe[0] <= 1'b0;
      exp_pipe[0] <= '0;
    end else begin
      vld_pipe[0] <= rd_vld;
      exp_pipe[0] <= exp_now;
    end
  end

  for (genvar g = 1; g < RD_LATENCY; g++) begin : g_stage
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_pipe[g] <= 1'b0;
        exp_pipe[g] <= '0;
      end else begin
        vld_pipe[g] <= vld_pipe[g-1];
        exp_pipe[g] <= exp_pipe[g-1];
      end
    end
  end

  assign mismatch = vld_pipe[RD_LATENCY-1] && (rd_data != exp_pipe[RD_LATENCY-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr) begin
      err_cnt <= '0;
    end else if (mismatch && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
    end
  end

`ifdef RAM_2PORT_BIST_ERR_LOG_EN
  logic [ADDR_WIDTH-1:0] addr_pipe [RD_LATENCY];
  logic                  logged;

  always_ff @(posedge clk) begin
    if (!rst_n) addr_pipe[0] <= '0;
    else        addr_pipe[0] <= rd_addr;
  end

  for (genvar g = 1; g < RD_LATENCY; g++) begin : g_addr_stage
    always_ff @(posedge clk) begin
      if (!rst_n) addr_pipe[g] <= '0;
      else        addr_pipe[g] <= addr_pipe[g-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      first_err_addr <= '0;
      first_err_data <= '0;
      logged         <= 1'b0;
    end else if (mismatch && !logged) begin
      first_err_addr <= addr_pipe[RD_LATENCY-1];
      first_err_data <= rd_data;
      logged         <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/ram_2port_bist.sv
// rtl/ram_2port_bist.sv - BIST engine for a single-clock simple dual-port RAM
//
// Purpose: writes a selected pattern to every address, reads every address
// back, and reports pass/fail plus a saturating mismatch count.
// Optional macro: RAM_2PORT_BIST_ERR_LOG_EN adds first_err_addr/first_err_data.
// Ports: clk, rst_n (sync active-low), start (pulse, accepted when idle),
// mode (pattern select), busy, done (pulse), pass, err_cnt, ram (RAM bus,
// master modport: write port, read address, read data).
// RD_LATENCY must be 1 or 2.
module ram_2port_bist
  import ram_bist_pkg::*;
#(
  parameter int ADDR_WIDTH    = 5,
  parameter int DATA_WIDTH    = 8,
  parameter int RD_LATENCY    = 1,
  parameter int ERR_CNT_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [1:0]               mode,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
`ifdef RAM_2PORT_BIST_ERR_LOG_EN
  output logic [ADDR_WIDTH-1:0]    first_err_addr,
  output logic [DATA_WIDTH-1:0]    first_err_data,
`endif
  ram_2port_bist_if.master         ram
);

  // One extra bit so reaching DEPTH is distinguishable from address 0.
  localparam int                CNT_W      = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0]  DEPTH_CNT  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(RD_LATENCY - 1);

  bist_state_e           state;
  bist_mode_e            mode_q;
  logic [CNT_W-1:0]      cnt;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic                  rd_vld_q;
  logic                  start_ok;

  // done is high in the cycle right after ST_DONE, while the FSM already sits
  // in IDLE; a start in that cycle still belongs to the finishing test.
  assign start_ok = (state == ST_IDLE) && start && !done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_CNT_DN;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_addr_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            mode_q    <= bist_mode_e'(mode);
            pass      <= 1'b0;
            busy      <= 1'b1;
            wr_en_q   <= 1'b1;
            wr_addr_q <= '0;
            wr_data_q <= DATA_WIDTH'(bist_pattern(bist_mode_e'(mode), '0));
            cnt       <= CNT_W'(1);
            state     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // cnt is the next address to present.
          if (cnt == DEPTH_CNT) begin
            wr_en_q <= 1'b0;
            state   <= ST_GAP;
          end else begin
            wr_addr_q <= cnt[ADDR_WIDTH-1:0];
            wr_data_q <= DATA_WIDTH'(bist_pattern(mode_q, MAX_ADDR_WIDTH'(cnt[ADDR_WIDTH-1:0])));
            cnt       <= cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          rd_addr_q <= '0;
          rd_vld_q  <= 1'b1;
          cnt       <= CNT_W'(1);
          state     <= ST_READ;
        end
        ST_READ: begin
          if (cnt == DEPTH_CNT) begin
            rd_vld_q <= 1'b0;
            cnt      <= '0;
            state    <= ST_DRAIN;
          end else begin
            rd_addr_q <= cnt[ADDR_WIDTH-1:0];
            cnt       <= cnt + CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (cnt == DRAIN_LAST) state <= ST_DONE;
          else                   cnt   <= cnt + CNT_W'(1);
        end
        ST_DONE: begin
          // err_cnt now includes the final compare.
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= (err_cnt == '0);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ram.ram_wr_en   = wr_en_q;
  assign ram.ram_wr_addr = wr_addr_q;
  assign ram.ram_wr_data = wr_data_q;
  assign ram.ram_rd_addr = rd_addr_q;

  ram_bist_chk #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .RD_LATENCY    (RD_LATENCY),
    .ERR_CNT_WIDTH (ERR_CNT_WIDTH)
  ) u_chk (
    .clk            (clk),
    .rst_n          (rst_n),
    .clr            (start_ok),
    .mode           (mode_q),
    .rd_vld         (rd_vld_q),
    .rd_addr        (rd_addr_q),
    .rd_data        (ram.ram_rd_data),
`ifdef RAM_2PORT_BIST_ERR_LOG_EN
    .first_err_addr (first_err_addr),
    .first_err_data (first_err_data),
`endif
    .err_cnt        (err_cnt)
  );

endmodule

// File: tb/tb_ram_2port_bist.sv
// tb/tb_ram_2port_bist.sv - directed self-checking bench for ram_2port_bist
module tb_ram_2port_bist;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_errors = 0;

  // Instance 1: RD_LATENCY=1; instance 2: RD_LATENCY=2.
  logic       start1, start2;
  logic [1:0] mode1, mode2;
  logic       busy1, busy2, done1, done2, pass1, pass2;
  logic [2:0] err1, err2;
`ifdef RAM_2PORT_BIST_ERR_LOG_EN
  logic [4:0] fe_addr1, fe_addr2;
  logic [7:0] fe_data1, fe_data2;
`endif

  ram_2port_bist_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) bus1 ();
  ram_2port_bist_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) bus2 ();

  ram_2port_bist #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .RD_LATENCY(1), .ERR_CNT_WIDTH(3)) u_dut1 (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start1),
    .mode           (mode1),
    .busy           (busy1),
    .done           (done1),
    .pass           (pass1),
    .err_cnt        (err1),
`ifdef RAM_2PORT_BIST_ERR_LOG_EN
    .first_err_addr (fe_addr1),
    .first_err_data (fe_data1),
`endif
    .ram            (bus1)
  );

  ram_2port_bist #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .RD_LATENCY(2), .ERR_CNT_WIDTH(3)) u_dut2 (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start2),
    .mode           (mode2),
    .busy           (busy2),
    .done           (done2),
    .pass           (pass2),
    .err_cnt        (err2),
`ifdef RAM_2PORT_BIST_ERR_LOG_EN
    .first_err_addr (fe_addr2),
    .first_err_data (fe_data2),
`endif
    .ram            (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models. fault1: 0 = clean, 1 = flip bit 0 on reads of address 7,
  // 2 = every read returns 0.
  logic [7:0] mem1 [32];
  logic [7:0] mem2 [32];
  logic [7:0] rd2_s1;
  int         fault1 = 0;

  function automatic logic [7:0] ram1_rd(input logic [4:0] a);
    logic [7:0] d;
    d = mem1[a];
    if (fault1 == 1 && a == 5'd7) d = d ^ 8'h01;
    else if (fault1 == 2)         d = 8'h00;
    return d;
  endfunction

  always @(posedge clk) begin
    if (bus1.ram_wr_en) mem1[bus1.ram_wr_addr] <= bus1.ram_wr_data;
    bus1.ram_rd_data <= ram1_rd(bus1.ram_rd_addr);
  end

  always @(posedge clk) begin
    if (bus2.ram_wr_en) mem2[bus2.ram_wr_addr] <= bus2.ram_wr_data;
    rd2_s1           <= mem2[bus2.ram_rd_addr];
    bus2.ram_rd_data <= rd2_s1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Results of the last run_test.
  int         r_done_cyc;
  int         r_n_done;
  logic       r_pass;
  logic [2:0] r_err;
  logic       r_busy_c1;
  logic       r_busy_done;
  logic       r_busy_rst;
  logic       r_pass_rst;

  // Start pulse in cycle 0; outputs sampled on the falling edge of cycles
  // 1..150. extra_cyc re-pulses start, rst_cyc pulls rst_n low for one cycle.
  task automatic run_test(input int which, input logic [1:0] m, input int extra_cyc, input int rst_cyc);
    logic d, p, b;
    logic [2:0] e;
    r_done_cyc = -1; r_n_done = 0; r_pass = 1'bx; r_err = 3'bx;
    r_busy_c1 = 1'bx; r_busy_done = 1'bx; r_busy_rst = 1'bx; r_pass_rst = 1'bx;
    @(negedge clk);
    if (which == 1) begin start1 = 1'b1; mode1 = m; end
    else            begin start2 = 1'b1; mode2 = m; end
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      d = (which == 1) ? done1 : done2;
      p = (which == 1) ? pass1 : pass2;
      b = (which == 1) ? busy1 : busy2;
      e = (which == 1) ? err1  : err2;
      if (d) begin
        r_n_done++;
        if (r_done_cyc < 0) begin
          r_done_cyc = k; r_pass = p; r_err = e; r_busy_done = b;
        end
      end
      if (k == 1) r_busy_c1 = b;
      if (k == rst_cyc + 1) begin r_busy_rst = b; r_pass_rst = p; end
      if (which == 1) start1 = (k == extra_cyc);
      else            start2 = (k == extra_cyc);
      rst_n = (k != rst_cyc);
    end
    start1 = 1'b0; start2 = 1'b0; rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; mode1 = 2'd0; mode2 = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_busy",    64'(busy1), 64'd0);
    check("rst_done",    64'(done1), 64'd0);
    check("rst_pass",    64'(pass1), 64'd0);
    check("rst_err_cnt", 64'(err1), 64'd0);
    check("rst_wr_en",   64'(bus1.ram_wr_en), 64'd0);
    check("rst_wr_addr", 64'(bus1.ram_wr_addr), 64'd0);
    check("rst_wr_data", 64'(bus1.ram_wr_data), 64'd0);
    check("rst_rd_addr", 64'(bus1.ram_rd_addr), 64'd0);
    rst_n = 1'b1;

    // Mode 0, latency 1.
    run_test(1, 2'd0, -1, -1);
    check("t1_mem0",      64'(mem1[0]), 64'hFF);
    check("t1_mem31",     64'(mem1[31]), 64'hE0);
    check("t1_done_cyc",  64'(r_done_cyc), 64'd68);
    check("t1_n_done",    64'(r_n_done), 64'd1);
    check("t1_pass",      64'(r_pass), 64'd1);
    check("t1_err_cnt",   64'(r_err), 64'd0);
    check("t1_busy_c1",   64'(r_busy_c1), 64'd1);
    check("t1_busy_done", 64'(r_busy_done), 64'd0);

    // Checkerboard, latency 2.
    run_test(2, 2'd2, -1, -1);
    check("t2_mem0",     64'(mem2[0]), 64'h55);
    check("t2_mem1",     64'(mem2[1]), 64'hAA);
    check("t2_mem31",    64'(mem2[31]), 64'hAA);
    check("t2_done_cyc", 64'(r_done_cyc), 64'd69);
    check("t2_pass",     64'(r_pass), 64'd1);
    check("t2_err_cnt",  64'(r_err), 64'd0);

    // Single bit flip at address 7.
    fault1 = 1;
    run_test(1, 2'd0, -1, -1);
    check("t3_done_cyc", 64'(r_done_cyc), 64'd68);
    check("t3_err_cnt",  64'(r_err), 64'd1);
    check("t3_pass",     64'(r_pass), 64'd0);
`ifdef RAM_2PORT_BIST_ERR_LOG_EN
    check("t3_first_err_addr", 64'(fe_addr1), 64'd7);
    check("t3_first_err_data", 64'(fe_data1), 64'hF9);
`endif

    // Stuck-at-zero read data, mode 1: 31 mismatches saturate at 7.
    fault1 = 2;
    run_test(1, 2'd1, -1, -1);
    check("t4_err_cnt", 64'(r_err), 64'd7);
    check("t4_pass",    64'(r_pass), 64'd0);
    fault1 = 0;

    // Second start during WRITE is ignored.
    run_test(1, 2'd0, 10, -1);
    check("t5_done_cyc", 64'(r_done_cyc), 64'd68);
    check("t5_n_done",   64'(r_n_done), 64'd1);
    check("t5_pass",     64'(r_pass), 64'd1);

    // Start coincident with the done pulse is ignored.
    run_test(1, 2'd0, 68, -1);
    check("t6_n_done",   64'(r_n_done), 64'd1);
    check("t6_busy_end", 64'(busy1), 64'd0);

    // Reset during READ aborts.
    run_test(1, 2'd0, -1, 40);
    check("t7_n_done",     64'(r_n_done), 64'd0);
    check("t7_busy_after", 64'(r_busy_rst), 64'd0);
    check("t7_pass_after", 64'(r_pass_rst), 64'd0);

    // Normal run after the abort.
    run_test(1, 2'd0, -1, -1);
    check("t8_done_cyc", 64'(r_done_cyc), 64'd68);
    check("t8_pass",     64'(r_pass), 64'd1);
    check("t8_err_cnt",  64'(r_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_2port_bist.md
Name: ram_2port_bist

Overview:
- Built-in self-test engine for a parametrised simple dual-port RAM (single-clock instance).
- Sequence: writes a selectable data pattern to every address, reads every address back, compares against the regenerated pattern, and reports pass/fail plus a saturating error count.
- Sits beside the RAM instance; owns its write and read ports during a test.

Parameters:
- ADDR_WIDTH, 5, RAM address width; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, RAM data width (1..1152).
- RD_LATENCY, 1, RAM read latency in cycles (1 = no output reg, 2 = output reg); other values illegal.
- ERR_CNT_WIDTH, 3, width of the saturating error counter.

Ports:
- clk  in  1  single clock for BIST and RAM.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; starts a test when idle.
- mode  in  2  pattern select, sampled on accepted start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at test end.
- pass  out  1  result of last test; valid from done until next start.
- err_cnt  out  ERR_CNT_WIDTH  mismatches in last test, saturating at all-ones.
- ram_wr_en  out  1  RAM write enable.
- ram_wr_addr  out  ADDR_WIDTH  RAM write address.
- ram_wr_data  out  DATA_WIDTH  RAM write data.
- ram_rd_addr  out  ADDR_WIDTH  RAM read address.
- ram_rd_data  in  DATA_WIDTH  RAM read data.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; busy, done, pass, ram_wr_en = 0; err_cnt, addresses and write data = 0.
- All outputs registered.
- Patterns, for address a:
  - mode 0: all-ones minus a, mod 2**DATA_WIDTH (descending counter).
  - mode 1: a, zero-extended or truncated to DATA_WIDTH.
  - mode 2: checkerboard; 0x55.. repeated for even a, inverted for odd a.
  - mode 3: bitwise inverse of mode 1.
- FSM states: IDLE, WRITE, GAP, READ, DRAIN, DONE.
- IDLE:
  - start=1 latches mode, clears err_cnt and pass, goes to WRITE.
  - start while not IDLE is ignored.
- WRITE: ram_wr_en=1 for exactly DEPTH cycles, addresses 0..DEPTH-1 ascending; then GAP.
- GAP: one cycle, ram_wr_en=0; guarantees the last write is visible before the first read.
- READ: ram_rd_addr steps 0..DEPTH-1, one per cycle.
- Compare pipeline:
  - An expected-data/valid shift register of depth RD_LATENCY aligns the pattern with ram_rd_data.
  - Data for the address driven in cycle n is compared at the end of cycle n+RD_LATENCY.
- DRAIN: RD_LATENCY cycles, until the last compare completes.
- DONE: one cycle; done=1; pass = (err_cnt==0 and no saturation); busy drops the same cycle; back to IDLE.
- Each mismatch increments err_cnt; it holds at all-ones and never wraps.
- Timing: with start sampled in cycle 0, done is high in cycle 2*DEPTH+RD_LATENCY+3.
- Address counter is ADDR_WIDTH+1 bits so the terminal count is detected without wrap aliasing.
- Reset mid-test aborts immediately:
  - RAM contents undefined.
  - done is not pulsed.
  - pass=0.
- start coincident with the DONE cycle is ignored.

Optional Feature:
- Macro: RAM_2PORT_BIST_ERR_LOG_EN.
- Defined:
  - Adds outputs first_err_addr [ADDR_WIDTH] and first_err_data [DATA_WIDTH].
  - These capture the address and read data of the first mismatch of the test.
  - Both clear to 0 on reset and on accepted start.
  - They hold if no error occurs.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package ram_bist_pkg holds:
  - mode enum (MODE_CNT_DN, MODE_ADDR, MODE_CHK, MODE_ADDR_INV);
  - FSM state typedef;
  - checkerboard constant generator;
  - pattern function (mode, addr) -> data.
- One sub-module: ram_bist_chk. It contains the RD_LATENCY-deep expected/valid pipeline, the comparator, the saturating err_cnt, and the optional error log.
- The top module keeps the FSM and address counters.

Test Plan:
- Defaults, bench RAM model with latency 1, mode 0, start pulse:
  - Write data at address 0 is 0xFF and at address 31 is 0xE0.
  - done is in cycle 68; pass=1; err_cnt=0.
- RD_LATENCY=2, mode 2, RAM model with output reg:
  - Address 0 holds 0x55 and address 1 holds 0xAA.
  - done is in cycle 69; pass=1.
- Mode 0, RAM model flips bit 0 on reads of address 7 (returns 0xF9, expected 0xF8):
  - err_cnt=1, pass=0.
  - With the macro: first_err_addr=7, first_err_data=0xF9.
- RAM model returns 0x00 on every read, mode 1:
  - 31 mismatches (address 0 matches); err_cnt saturates at 7; pass=0.
- Second start pulse during WRITE: ignored; single done at cycle 68.
- rst_n=0 for one cycle during READ:
  - busy=0, done never pulses, pass=0.
  - A subsequent start completes normally with pass=1.
